// File: rtl/ysyx_23060208_fetch_unit_pkg.sv
// Shared constants for the fetch stage: bus widths, reset PC and AXI response codes.
package ysyx_23060208_fetch_unit_pkg;

    localparam int          EXU_TO_IFU_BUS = 33;
    localparam int          IFU_TO_IDU_BUS = 64;
    localparam logic [31:0] RESET_PC_DEF   = 32'h8000_0000;
    localparam logic [1:0]  RESP_OKAY      = 2'b00;

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_23060208_fetch_unit_axi_rd_master.sv
// Single-outstanding AXI-lite read master: registered arvalid/rready, OKAY/error split of the R beat.
module ysyx_23060208_fetch_unit_axi_rd_master
    import ysyx_23060208_fetch_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] addr_i,
    output logic [DATA_WIDTH-1:0] araddr_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rvalid_i,
    output logic                  rready_o,
    output logic                  ar_hs_o,
    output logic                  r_ok_o,
    output logic                  r_err_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  done_o
);

    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic [DATA_WIDTH-1:0] araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  done_q;
    logic                  r_hs;

    assign ar_hs_o = arvalid_q && arready_i;
    assign r_hs    = rready_q && rvalid_i;
    assign r_ok_o  = r_hs && (rresp_i == RESP_OKAY);
    assign r_err_o = r_hs && (rresp_i != RESP_OKAY);

    always_comb begin
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        araddr_d  = araddr_q;
        rdata_d   = rdata_q;
        if (start_i) begin
            arvalid_d = 1'b1;
            araddr_d  = addr_i;
        end else if (ar_hs_o) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
        end
        if (r_hs) begin
            rready_d = 1'b0;
        end
        if (r_ok_o) begin
            rdata_d = rdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            araddr_q  <= '0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            araddr_q  <= araddr_d;
            rdata_q   <= rdata_d;
            done_q    <= r_ok_o;
        end
    end

    assign araddr_o  = araddr_q;
    assign arvalid_o = arvalid_q;
    assign rready_o  = rready_q;
    assign rdata_o   = rdata_q;
    assign done_o    = done_q;

endmodule

// File: rtl/ysyx_23060208_fetch_unit.sv
// Instruction fetch stage: PC, one AXI-lite read per instruction, IDU handoff, EXU-driven next PC.
// Optional IFU_PERF_CNT_EN adds saturating fetch/stall counters readable through tasks.
//
// state      | meaning
// IDLE       | first cycle after reset release
// FETCH_AR   | address phase, arvalid held until arready
// FETCH_R    | data phase, rready held until rvalid
// ISSUE      | {pc, inst} offered to IDU until allowin
// WAIT_EXU   | waiting for EXU to retire and pick next PC
// HALT       | bad response or misaligned PC; left only by reset
module ysyx_23060208_fetch_unit
    import ysyx_23060208_fetch_unit_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [EXU_TO_IFU_BUS-1:0] exu_to_ifu_bus,
    input  logic                      exu_to_ifu_valid,
    output logic [IFU_TO_IDU_BUS-1:0] ifu_to_idu_bus,
    output logic                      ifu_to_idu_valid,
    input  logic                      idu_allowin,
    output logic [DATA_WIDTH-1:0]     isram_araddr,
    output logic                      isram_arvalid,
    input  logic                      isram_arready,
    input  logic [DATA_WIDTH-1:0]     isram_rdata,
    input  logic [1:0]                isram_rresp,
    input  logic                      isram_rvalid,
    output logic                      isram_rready,
    output logic                      ifu_done,
    output logic                      ifu_fault
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH_AR = 3'd1;
    localparam logic [2:0] S_FETCH_R  = 3'd2;
    localparam logic [2:0] S_ISSUE    = 3'd3;
    localparam logic [2:0] S_WAIT_EXU = 3'd4;
    localparam logic [2:0] S_HALT     = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  fault_q, fault_d;
    logic [DATA_WIDTH-1:0] next_pc;
    logic [DATA_WIDTH-1:0] inst;
    logic                  start, ar_hs, r_ok, r_err;

    ysyx_23060208_fetch_unit_axi_rd_master #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_rd (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start),
        .addr_i    (pc_d),
        .araddr_o  (isram_araddr),
        .arvalid_o (isram_arvalid),
        .arready_i (isram_arready),
        .rdata_i   (isram_rdata),
        .rresp_i   (isram_rresp),
        .rvalid_i  (isram_rvalid),
        .rready_o  (isram_rready),
        .ar_hs_o   (ar_hs),
        .r_ok_o    (r_ok),
        .r_err_o   (r_err),
        .rdata_o   (inst),
        .done_o    (ifu_done)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        start   = 1'b0;
        next_pc = exu_to_ifu_bus[DATA_WIDTH] ? exu_to_ifu_bus[DATA_WIDTH-1:0]
                                             : pc_q + DATA_WIDTH'(4);
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH_AR;
                start   = 1'b1;
            end
            S_FETCH_AR: if (ar_hs) state_d = S_FETCH_R;
            S_FETCH_R: begin
                if (r_ok) begin
                    state_d = S_ISSUE;
                end else if (r_err) begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end
            end
            S_ISSUE: if (idu_allowin) state_d = S_WAIT_EXU;
            S_WAIT_EXU: begin
                if (exu_to_ifu_valid) begin
                    // A misaligned target stops here without committing it to pc.
                    if (pc_misaligned(next_pc)) begin
                        fault_d = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        pc_d    = next_pc;
                        state_d = S_FETCH_AR;
                        start   = 1'b1;
                    end
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    assign ifu_to_idu_valid = (state_q == S_ISSUE);
    assign ifu_to_idu_bus   = ifu_to_idu_valid ? {pc_q, inst} : '0;
    assign ifu_fault        = fault_q;

    exu_valid_only_in_wait: assert property (
        @(posedge clk) disable iff (!rst) exu_to_ifu_valid |-> (state_q == S_WAIT_EXU));

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;
    logic        stall;

    assign stall = (isram_arvalid && !isram_arready) || (isram_rready && !isram_rvalid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (r_ok && fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    task get_ifu_fetch_cnt(output int cnt);
        cnt = int'(fetch_cnt_q);
    endtask

    task get_ifu_stall_cnt(output int cnt);
        cnt = int'(stall_cnt_q);
    endtask
`endif

endmodule

// File: tb/tb_ysyx_23060208_fetch_unit.sv
// Bench for the fetch unit: directed vector table, hand sequences for stalls/faults/reset, random run vs PC model.
module tb_ysyx_23060208_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [32:0] exu_to_ifu_bus;
    logic        exu_to_ifu_valid;
    logic [63:0] ifu_to_idu_bus;
    logic        ifu_to_idu_valid;
    logic        idu_allowin;
    logic [31:0] isram_araddr;
    logic        isram_arvalid;
    logic        isram_arready;
    logic [31:0] isram_rdata;
    logic [1:0]  isram_rresp;
    logic        isram_rvalid;
    logic        isram_rready;
    logic        ifu_done;
    logic        ifu_fault;

    int n_vec = 0;
    int n_bad = 0;

    ysyx_23060208_fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .exu_to_ifu_bus   (exu_to_ifu_bus),
        .exu_to_ifu_valid (exu_to_ifu_valid),
        .ifu_to_idu_bus   (ifu_to_idu_bus),
        .ifu_to_idu_valid (ifu_to_idu_valid),
        .idu_allowin      (idu_allowin),
        .isram_araddr     (isram_araddr),
        .isram_arvalid    (isram_arvalid),
        .isram_arready    (isram_arready),
        .isram_rdata      (isram_rdata),
        .isram_rresp      (isram_rresp),
        .isram_rvalid     (isram_rvalid),
        .isram_rready     (isram_rready),
        .ifu_done         (ifu_done),
        .ifu_fault        (ifu_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        e_arvalid;
        logic [31:0] e_araddr;
        logic        e_rready;
        logic        e_ivalid;
        logic [63:0] e_bus;
        logic        e_done;
        logic        e_fault;
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        allowin;
        logic        exu_v;
        logic [32:0] exu_bus;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        exu_to_ifu_bus   = '0;
        exu_to_ifu_valid = 1'b0;
        idu_allowin      = 1'b0;
        isram_arready    = 1'b0;
        isram_rdata      = '0;
        isram_rresp      = 2'b00;
        isram_rvalid     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (2) step();
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc_m;
        logic [31:0] inst_m;
        logic [31:0] tgt;
        logic        taken;
        logic        hs;
        int          guard;
        bit          aborted;

        //            arv  araddr        rrdy ivld bus                         done flt | ardy rv  rdata         rresp alw exu  exu_bus
        tbl[0] = '{1'b1, 32'h8000_0000, 1'b0, 1'b0, 64'h0,                     1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         2'b00, 1'b0, 1'b0, 33'h0};
        tbl[1] = '{1'b0, 32'h0,         1'b1, 1'b0, 64'h0,                     1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0013, 2'b00, 1'b0, 1'b0, 33'h0};
        tbl[2] = '{1'b0, 32'h0,         1'b0, 1'b1, 64'h8000_0000_0000_0013,   1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         2'b00, 1'b1, 1'b0, 33'h0};
        tbl[3] = '{1'b0, 32'h0,         1'b0, 1'b0, 64'h0,                     1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, 1'b1, {1'b0, 32'h1234_5679}};
        tbl[4] = '{1'b1, 32'h8000_0004, 1'b0, 1'b0, 64'h0,                     1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         2'b00, 1'b0, 1'b0, 33'h0};
        tbl[5] = '{1'b0, 32'h0,         1'b1, 1'b0, 64'h0,                     1'b0, 1'b0, 1'b0, 1'b1, 32'h0010_0093, 2'b00, 1'b0, 1'b0, 33'h0};
        tbl[6] = '{1'b0, 32'h0,         1'b0, 1'b1, 64'h8000_0004_0010_0093,   1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         2'b00, 1'b1, 1'b0, 33'h0};
        tbl[7] = '{1'b0, 32'h0,         1'b0, 1'b0, 64'h0,                     1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, 1'b1, {1'b1, 32'h8000_0100}};
        tbl[8] = '{1'b1, 32'h8000_0100, 1'b0, 1'b0, 64'h0,                     1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'b00, 1'b0, 1'b0, 33'h0};

        // Reset state
        rst = 1'b0;
        idle_inputs();
        step();
        check("rst_arvalid", isram_arvalid, 1'b0);
        check("rst_araddr", isram_araddr, 32'h0);
        check("rst_rready", isram_rready, 1'b0);
        check("rst_ivalid", ifu_to_idu_valid, 1'b0);
        check("rst_bus", ifu_to_idu_bus, 64'h0);
        check("rst_done", ifu_done, 1'b0);
        check("rst_fault", ifu_fault, 1'b0);
        step();
        rst = 1'b1;

        // Directed table: observe expected outputs, then drive the row's inputs
        for (int i = 0; i < 9; i++) begin
            step();
            check($sformatf("tbl%0d_arvalid", i), isram_arvalid, tbl[i].e_arvalid);
            if (tbl[i].e_arvalid) check($sformatf("tbl%0d_araddr", i), isram_araddr, tbl[i].e_araddr);
            check($sformatf("tbl%0d_rready", i), isram_rready, tbl[i].e_rready);
            check($sformatf("tbl%0d_ivalid", i), ifu_to_idu_valid, tbl[i].e_ivalid);
            if (tbl[i].e_ivalid) check($sformatf("tbl%0d_bus", i), ifu_to_idu_bus, tbl[i].e_bus);
            check($sformatf("tbl%0d_done", i), ifu_done, tbl[i].e_done);
            check($sformatf("tbl%0d_fault", i), ifu_fault, tbl[i].e_fault);
            isram_arready    = tbl[i].arready;
            isram_rvalid     = tbl[i].rvalid;
            isram_rdata      = tbl[i].rdata;
            isram_rresp      = tbl[i].rresp;
            idu_allowin      = tbl[i].allowin;
            exu_to_ifu_valid = tbl[i].exu_v;
            exu_to_ifu_bus   = tbl[i].exu_bus;
        end

        // arready stall: address phase must hold
        for (int k = 0; k < 5; k++) begin
            step();
            check("arstall_arvalid", isram_arvalid, 1'b1);
            check("arstall_araddr", isram_araddr, 32'h8000_0100);
            check("arstall_rready", isram_rready, 1'b0);
        end
        isram_arready = 1'b1;
        step();
        check("rphase_rready", isram_rready, 1'b1);
        check("rphase_arvalid", isram_arvalid, 1'b0);
        isram_arready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            check("rstall_rready", isram_rready, 1'b1);
            check("rstall_ivalid", ifu_to_idu_valid, 1'b0);
        end
        isram_rvalid = 1'b1;
        isram_rdata  = 32'h0020_0113;
        step();
        isram_rvalid = 1'b0;
        check("rstall_issue_valid", ifu_to_idu_valid, 1'b1);
        check("rstall_issue_bus", ifu_to_idu_bus, 64'h8000_0100_0020_0113);
        check("rstall_done", ifu_done, 1'b1);

        // IDU back-pressure: bus holds, no new AR
        for (int k = 0; k < 4; k++) begin
            step();
            check("allowin_stall_valid", ifu_to_idu_valid, 1'b1);
            check("allowin_stall_bus", ifu_to_idu_bus, 64'h8000_0100_0020_0113);
            check("allowin_stall_arvalid", isram_arvalid, 1'b0);
            check("allowin_stall_done", ifu_done, 1'b0);
        end
        idu_allowin = 1'b1;
        step();
        idu_allowin = 1'b0;
        check("post_accept_valid", ifu_to_idu_valid, 1'b0);

        // Misaligned redirect -> HALT with sticky fault
        exu_to_ifu_valid = 1'b1;
        exu_to_ifu_bus   = {1'b1, 32'h8000_0102};
        step();
        exu_to_ifu_valid = 1'b0;
        exu_to_ifu_bus   = '0;
        for (int k = 0; k < 4; k++) begin
            check("misalign_fault", ifu_fault, 1'b1);
            check("misalign_arvalid", isram_arvalid, 1'b0);
            check("misalign_ivalid", ifu_to_idu_valid, 1'b0);
            step();
        end

        // Error response -> HALT
        do_reset();
        step();
        check("resp_fault_cleared", ifu_fault, 1'b0);
        check("resp_araddr", isram_araddr, 32'h8000_0000);
        isram_arready = 1'b1;
        step();
        isram_arready = 1'b0;
        check("resp_rready", isram_rready, 1'b1);
        isram_rvalid = 1'b1;
        isram_rresp  = 2'b10;
        isram_rdata  = 32'hDEAD_BEEF;
        step();
        isram_rvalid = 1'b0;
        isram_rresp  = 2'b00;
        check("resp_done", ifu_done, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check("resp_fault", ifu_fault, 1'b1);
            check("resp_halt_arvalid", isram_arvalid, 1'b0);
            check("resp_halt_ivalid", ifu_to_idu_valid, 1'b0);
            step();
        end

        // Reset in the middle of FETCH_R
        do_reset();
        step();
        isram_arready = 1'b1;
        step();
        isram_arready = 1'b0;
        check("midr_rready", isram_rready, 1'b1);
        rst = 1'b0;
        #1;
        check("midr_async_rready", isram_rready, 1'b0);
        check("midr_async_arvalid", isram_arvalid, 1'b0);
        check("midr_async_araddr", isram_araddr, 32'h0);
        step();
        rst = 1'b1;
        step();
        check("midr_restart_arvalid", isram_arvalid, 1'b1);
        check("midr_restart_araddr", isram_araddr, 32'h8000_0000);

        // Randomized run against a PC-sequence model
        do_reset();
        pc_m    = 32'h8000_0000;
        aborted = 1'b0;
        for (int n = 0; n < 150; n++) begin
            hs = 1'b0;
            guard = 0;
            while (!hs && guard < 50) begin
                step();
                exu_to_ifu_valid = 1'b0;
                guard++;
                check("rnd_ivalid_idle", ifu_to_idu_valid, 1'b0);
                if (isram_arvalid) begin
                    check("rnd_araddr", isram_araddr, pc_m);
                    isram_arready = ($urandom_range(0, 2) == 0);
                    hs = isram_arready;
                end else begin
                    isram_arready = 1'b0;
                end
            end
            if (!hs) begin
                check("rnd_ar_timeout", 1'b0, 1'b1);
                aborted = 1'b1;
                break;
            end

            hs = 1'b0;
            guard = 0;
            while (!hs && guard < 50) begin
                step();
                isram_arready = 1'b0;
                guard++;
                check("rnd_done_wait", ifu_done, 1'b0);
                if (isram_rready) begin
                    isram_rvalid = ($urandom_range(0, 2) == 0);
                    isram_rdata  = $urandom;
                    isram_rresp  = 2'b00;
                    inst_m       = isram_rdata;
                    hs           = isram_rvalid;
                end else begin
                    isram_rvalid = 1'b0;
                end
            end
            if (!hs) begin
                check("rnd_r_timeout", 1'b0, 1'b1);
                aborted = 1'b1;
                break;
            end

            step();
            isram_rvalid = 1'b0;
            check("rnd_done", ifu_done, 1'b1);
            hs = 1'b0;
            guard = 0;
            while (!hs && guard < 50) begin
                if (guard > 0) step();
                guard++;
                check("rnd_ivalid", ifu_to_idu_valid, 1'b1);
                check("rnd_bus", ifu_to_idu_bus, {pc_m, inst_m});
                idu_allowin = ($urandom_range(0, 1) == 0);
                hs = idu_allowin;
            end
            if (!hs) begin
                check("rnd_issue_timeout", 1'b0, 1'b1);
                aborted = 1'b1;
                break;
            end

            step();
            idu_allowin = 1'b0;
            check("rnd_ivalid_drop", ifu_to_idu_valid, 1'b0);
            check("rnd_fault", ifu_fault, 1'b0);
            repeat ($urandom_range(0, 2)) step();
            taken = $urandom_range(0, 1);
            case ($urandom_range(0, 7))
                0:       tgt = 32'hFFFF_FFFC;
                1:       tgt = 32'hFFFF_FFF8;
                default: tgt = $urandom & 32'hFFFF_FFFC;
            endcase
            exu_to_ifu_valid = 1'b1;
            exu_to_ifu_bus   = {taken, taken ? tgt : ($urandom | 32'h1)};
            pc_m = taken ? tgt : pc_m + 32'd4;
        end
        if (!aborted) begin
            step();
            exu_to_ifu_valid = 1'b0;
            check("rnd_final_araddr", isram_araddr, pc_m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_23060208_fetch_unit.md
Name: ysyx_23060208_fetch_unit

Overview:
Instruction fetch stage of the multi-cycle core. It holds the architectural PC and issues one read per instruction over the AXI-lite read channels to the instruction SRAM. It hands {pc, inst} to the IDU with a valid/allowin handshake. It then waits for the EXU's completion bus to select the next PC: the redirect target or pc+4.

Parameters:
DATA_WIDTH, 32, address/data width
RESET_PC, 32'h8000_0000, PC after reset

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
exu_to_ifu_bus  in  33  {nextpc_taken, nextpc[31:0]} from EXU
exu_to_ifu_valid  in  1  EXU retired current instruction; bus valid this cycle
ifu_to_idu_bus  out  64  {pc[31:0], inst[31:0]}
ifu_to_idu_valid  out  1  bus holds a fetched instruction
idu_allowin  in  1  IDU accepts this cycle
isram_araddr  out  32  read address
isram_arvalid  out  1  read request valid
isram_arready  in  1  slave accepts address
isram_rdata  in  32  read data
isram_rresp  in  2  response, 2'b00 = OKAY
isram_rvalid  in  1  read data valid
isram_rready  out  1  master ready for data
ifu_done  out  1  pulse when R handshake completes, to arbiter
ifu_fault  out  1  sticky fault: bad rresp or misaligned PC

Behaviour:
- Reset (rst=0, async): state=IDLE, pc=RESET_PC, all outputs 0, inst reg 0, ifu_fault=0.
- States: IDLE, FETCH_AR, FETCH_R, ISSUE, WAIT_EXU, HALT.
- IDLE: one cycle after reset deassertion, go to FETCH_AR.
- FETCH_AR:
  - arvalid=1, araddr=pc, both held stable until arready=1.
  - On arready, go to FETCH_R in the next cycle; arvalid drops then.
- FETCH_R:
  - rready=1; wait for rvalid.
  - On rvalid && rresp==00: latch rdata into inst reg, pulse ifu_done for 1 cycle, go to ISSUE.
  - On rvalid && rresp!=00: set ifu_fault, go to HALT.
- ISSUE:
  - ifu_to_idu_valid=1, bus = {pc, inst_r}, held stable until idu_allowin=1.
  - On handshake, go to WAIT_EXU; valid drops the next cycle.
- WAIT_EXU:
  - On exu_to_ifu_valid: next = taken ? nextpc : pc+4 (mod 2^32, wraps 0xFFFF_FFFC->0).
  - If next[1:0]!=0: set ifu_fault, go to HALT, pc unchanged.
  - Otherwise pc<=next, go to FETCH_AR.
- HALT: all handshake outputs 0; exit only by reset.
- Minimum latency PC→IDU valid: 3 cycles (AR 1, R 1, ISSUE). Arready/rvalid stalls add cycle for cycle.
- exu_to_ifu_valid outside WAIT_EXU is ignored (simulation assertion flags it).
- Reset mid-transaction abandons the outstanding read. Slave must tolerate this; no drain.
- arvalid and rready are registered, never combinational from arready/rvalid.

Optional Feature:
IFU_PERF_CNT_EN
- Defined:
  - Adds 32-bit saturating counters fetch_cnt (completed R handshakes) and stall_cnt (cycles in FETCH_AR/FETCH_R with arvalid&&!arready or rready&&!rvalid).
  - Both are exported via DPI-C tasks get_ifu_fetch_cnt / get_ifu_stall_cnt and reset to 0.
- Undefined: counters and tasks absent; ports and timing identical.

Decomposition:
- Shared header ysyx_23060208_npc.h: EXU_TO_IFU_BUS (33), IFU_TO_IDU_BUS (64), RESET_PC, AXI resp codes (RESP_OKAY=2'b00).
- FSM state encodings stay local.
- One natural sub-module: ysyx_23060208_axi_rd_master (AR/R handshake, fault detect), reusable by EXU load path.

Test Plan:
- Reset release, slave arready=1, rvalid next cycle with rdata=0x00000013 (nop) -> araddr=0x80000000; ifu_to_idu_bus={0x80000000,0x00000013} valid 3 cycles after IDLE exit; ifu_done one cycle pulse.
- After IDU accept, exu_to_ifu_valid with bus {0, x} -> next araddr=0x80000004.
- exu_to_ifu_valid with {1, 0x80000100} -> next araddr=0x80000100; redirect not applied before WAIT_EXU.
- arready held 0 for 5 cycles, rvalid delayed 3 cycles -> arvalid/araddr stable throughout; ISSUE reached exactly after rvalid; stall_cnt=8 with IFU_PERF_CNT_EN.
- idu_allowin held 0 for 4 cycles -> valid and bus stable; no new AR issued.
- rresp=2'b10, or redirect to 0x80000102 -> ifu_fault=1, HALT, no further arvalid until rst low; rst low mid-FETCH_R -> pc=0x80000000, outputs 0 immediately.
